// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FULL  = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request bus plus the IF/ID handshake of the fetch stage.
interface fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr_IF;
    logic [31:0] PC_IF;
    logic        valid_IF;
    logic        stall_ID;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, instr_IF, PC_IF, valid_IF,
        input  imem_gnt, imem_rvalid, imem_rdata, stall_ID, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr_IF, PC_IF, valid_IF,
        output imem_gnt, imem_rvalid, imem_rdata, stall_ID, redirect, redirect_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries (flush beats push/pop) and its
// overflow checker.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     CLOCK,
    input  logic                     RST,
    input  logic                     push,
    input  fetch_entry_t             wdata,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int              AW      = $clog2(DEPTH);
    localparam logic [AW:0]     DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]   PTR_ONE = AW'(1);
    localparam logic [AW:0]     CNT_ONE = (AW+1)'(1);

    fetch_entry_t  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          do_push_s;
    logic          do_pop_s;

    // Qualify requests: flush wins, a full FIFO only takes data alongside a pop.
    always_comb begin
        do_push_s = push && !flush && (!full || pop);
        do_pop_s  = pop && !flush && !empty;
    end

    // Storage array; no reset needed since count_r guards every read.
    always_ff @(posedge CLOCK) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge CLOCK) begin
        if (RST || flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign full  = (count_r == DEPTH_C);
    assign empty = (count_r == '0);
    assign count = count_r;

endmodule

module fetch_fifo_chk (
    input logic CLOCK,
    input logic RST,
    input logic push,
    input logic pop,
    input logic flush,
    input logic full
);

    property p_no_push_when_full;
        @(posedge CLOCK) disable iff (RST) !(push && full && !pop && !flush);
    endproperty

    a_no_push_when_full: assert property (p_no_push_when_full);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC generation, imem req/gnt, prefetch buffering and
// redirect handling. FETCH_BYPASS_EN forwards a response into an empty FIFO.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic CLOCK,
    input  logic RST,
    fetch_if.master bus
);

    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    fetch_state_t  state_r;
    fetch_state_t  state_s;
    fetch_state_t  fsm_next_s;
    logic          fsm_req_s;
    logic [31:0]   fetch_pc_r;
    logic [31:0]   req_pc_r;
    logic          outstanding_r;
    logic          kill_r;

    logic          redirect_s;
    logic          req_s;
    logic          grant_s;
    logic          room_s;
    logic [CW:0]   occ_s;
    logic          rsp_ok_s;
    logic          bypass_s;
    logic          valid_s;
    logic          take_s;
    logic [31:0]   out_pc_s;
    logic [31:0]   out_instr_s;

    logic          push_s;
    logic          pop_s;
    logic          flush_s;
    fetch_entry_t  wdata_s;
    fetch_entry_t  head_s;
    logic          full_s;
    logic          empty_s;
    logic [CW-1:0] count_s;

    // Request gating: in-flight response counts against free FIFO slots.
    always_comb begin
        occ_s      = {1'b0, count_s} + {{CW{1'b0}}, outstanding_r};
        room_s     = (occ_s < DEPTH_W);
        redirect_s = bus.redirect && (state_r != S_IDLE);
        rsp_ok_s   = bus.imem_rvalid && !kill_r && (state_r != S_IDLE);
    end

    // FSM next state and request before redirect override.
    always_comb begin
        fsm_next_s = state_r;
        fsm_req_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                fsm_next_s = S_FETCH;
            end
            S_FETCH: begin
                if (room_s) begin
                    fsm_req_s  = 1'b1;
                    fsm_next_s = S_FETCH;
                end else begin
                    fsm_req_s  = 1'b0;
                    fsm_next_s = S_FULL;
                end
            end
            S_FULL: begin
                if (room_s) begin
                    fsm_next_s = S_FETCH;
                end else begin
                    fsm_next_s = S_FULL;
                end
            end
            default: begin
                fsm_next_s = S_IDLE;
                fsm_req_s  = 1'b0;
            end
        endcase
        state_s = redirect_s ? S_FETCH : fsm_next_s;
        req_s   = fsm_req_s && !redirect_s;
        grant_s = req_s && bus.imem_gnt;
    end

    // Output selection, FIFO push/pop and the optional same-cycle bypass.
    always_comb begin
`ifdef FETCH_BYPASS_EN
        bypass_s = rsp_ok_s && empty_s && !redirect_s;
`else
        bypass_s = 1'b0;
`endif
        valid_s     = !empty_s || bypass_s;
        out_pc_s    = bypass_s ? req_pc_r : head_s.pc;
        out_instr_s = bypass_s ? bus.imem_rdata : head_s.instr;
        take_s      = valid_s && !bus.stall_ID;
        push_s      = rsp_ok_s && !redirect_s && !(bypass_s && take_s);
        pop_s       = take_s && !bypass_s && !redirect_s;
        flush_s     = redirect_s;
        wdata_s     = '{pc: req_pc_r, instr: bus.imem_rdata};
    end

    // State, fetch PC, in-flight tracking and stale-response kill.
    always_ff @(posedge CLOCK) begin
        if (RST) begin
            state_r       <= S_IDLE;
            fetch_pc_r    <= word_align(RESET_PC);
            req_pc_r      <= 32'h0000_0000;
            outstanding_r <= 1'b0;
            kill_r        <= 1'b0;
        end else begin
            state_r <= state_s;
            if (redirect_s) begin
                fetch_pc_r <= word_align(bus.redirect_pc);
            end else if (grant_s) begin
                fetch_pc_r <= fetch_pc_r + 32'd4;
            end
            if (grant_s) begin
                req_pc_r      <= fetch_pc_r;
                outstanding_r <= 1'b1;
            end else if (bus.imem_rvalid) begin
                outstanding_r <= 1'b0;
            end
            // A response landing in the redirect cycle is discarded by the flush,
            // so only one still in flight afterwards needs killing.
            if (redirect_s) begin
                kill_r <= grant_s || ((outstanding_r || kill_r) && !bus.imem_rvalid);
            end else if (bus.imem_rvalid && kill_r) begin
                kill_r <= 1'b0;
            end
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLOCK (CLOCK),
        .RST   (RST),
        .push  (push_s),
        .wdata (wdata_s),
        .pop   (pop_s),
        .flush (flush_s),
        .head  (head_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    fetch_fifo_chk u_fifo_chk (
        .CLOCK (CLOCK),
        .RST   (RST),
        .push  (push_s),
        .pop   (pop_s),
        .flush (flush_s),
        .full  (full_s)
    );

    assign bus.imem_req  = req_s;
    assign bus.imem_addr = fetch_pc_r;
    assign bus.valid_IF  = valid_s;
    assign bus.instr_IF  = valid_s ? out_instr_s : NOP_INSTR;
    assign bus.PC_IF     = valid_s ? out_pc_s : 32'h0000_0000;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: start-up, stall/backpressure, redirect,
// PC wrap and mid-operation reset, with a 1-cycle-latency memory model.
module tb_fetch_unit;
    import fetch_pkg::*;

`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic CLOCK = 1'b0;
    logic RST   = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    fetch_if bus0 ();
    fetch_if bus1 ();

    fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut0 (
        .CLOCK (CLOCK),
        .RST   (RST),
        .bus   (bus0.master)
    );

    fetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut1 (
        .CLOCK (CLOCK),
        .RST   (RST),
        .bus   (bus1.master)
    );

    always #5 CLOCK = ~CLOCK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_0000;
    endfunction

    // Instruction memory: every granted request answers exactly one cycle later.
    always @(posedge CLOCK) begin
        bus0.imem_rvalid <= bus0.imem_req && bus0.imem_gnt;
        bus0.imem_rdata  <= mem_word(bus0.imem_addr);
        bus1.imem_rvalid <= bus1.imem_req && bus1.imem_gnt;
        bus1.imem_rdata  <= mem_word(bus1.imem_addr);
    end

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_if(input string tag, input logic v, input logic [31:0] pc);
        check_vec({tag, "_valid"}, {31'd0, bus0.valid_IF}, {31'd0, v});
        check_vec({tag, "_pc"}, bus0.PC_IF, v ? pc : 32'h0000_0000);
        check_vec({tag, "_instr"}, bus0.instr_IF, v ? mem_word(pc) : NOP_INSTR);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLOCK);
        #1;
    endtask

    initial begin
        bus0.imem_gnt = 1'b1; bus0.stall_ID = 1'b0; bus0.redirect = 1'b0; bus0.redirect_pc = 32'h0;
        bus1.imem_gnt = 1'b1; bus1.stall_ID = 1'b0; bus1.redirect = 1'b0; bus1.redirect_pc = 32'h0;
        RST = 1'b1;

        // Reset state, then start-up sequence
        step(3);
        check_vec("rst_req", {31'd0, bus0.imem_req}, 32'd0);
        check_vec("rst_req1", {31'd0, bus1.imem_req}, 32'd0);
        check_if("rst", 1'b0, 32'h0);
        RST = 1'b0;
        step(1);
        check_vec("e1_req", {31'd0, bus0.imem_req}, 32'd1);
        check_vec("e1_addr", bus0.imem_addr, 32'h0000_0000);
        check_vec("wrap_a0", bus1.imem_addr, 32'hFFFF_FFF8);
        check_if("e1", 1'b0, 32'h0);
        step(1);
        check_vec("e2_addr", bus0.imem_addr, 32'h0000_0004);
        check_vec("wrap_a1", bus1.imem_addr, 32'hFFFF_FFFC);
        check_if("e2", BYP, 32'h0);
        step(1);
        check_vec("e3_addr", bus0.imem_addr, 32'h0000_0008);
        check_vec("wrap_a2", bus1.imem_addr, 32'h0000_0000);
        check_if("e3", 1'b1, BYP ? 32'h4 : 32'h0);
        step(1);
        check_vec("e4_addr", bus0.imem_addr, 32'h0000_000C);
        check_if("e4", 1'b1, BYP ? 32'h8 : 32'h4);
        step(1);
        check_if("e5", 1'b1, BYP ? 32'hC : 32'h8);

        // Backpressure from reset: exactly DEPTH entries buffered
        RST = 1'b1;
        bus0.stall_ID = 1'b1;
        step(2);
        RST = 1'b0;
        check_vec("st_idle_req", {31'd0, bus0.imem_req}, 32'd0);
        step(10);
        check_vec("st_full_req", {31'd0, bus0.imem_req}, 32'd0);
        check_vec("st_full_addr", bus0.imem_addr, 32'h0000_0010);
        check_if("st_hold", 1'b1, 32'h0);
        bus0.stall_ID = 1'b0;
        step(1);
        check_vec("rel1_req", {31'd0, bus0.imem_req}, 32'd0);
        check_if("rel1", 1'b1, 32'h4);
        step(1);
        check_vec("rel2_req", {31'd0, bus0.imem_req}, 32'd1);
        check_vec("rel2_addr", bus0.imem_addr, 32'h0000_0010);
        check_if("rel2", 1'b1, 32'h8);
        step(1);
        check_if("rel3", 1'b1, 32'hC);
        step(1);
        check_if("rel4", 1'b1, 32'h10);

        // Redirect while a response is in flight
        bus0.redirect = 1'b1;
        bus0.redirect_pc = 32'h0000_0103;
        #1;
        check_vec("rd_req", {31'd0, bus0.imem_req}, 32'd0);
        step(1);
        bus0.redirect = 1'b0;
        #1;
        check_vec("rd1_req", {31'd0, bus0.imem_req}, 32'd1);
        check_vec("rd1_addr", bus0.imem_addr, 32'h0000_0100);
        check_if("rd1", 1'b0, 32'h0);
        step(1);
        check_vec("rd2_addr", bus0.imem_addr, 32'h0000_0104);
        check_if("rd2", BYP, 32'h100);
        step(1);
        check_if("rd3", 1'b1, BYP ? 32'h104 : 32'h100);
        step(1);
        check_if("rd4", 1'b1, BYP ? 32'h108 : 32'h104);

        // Reset while a response is due next cycle
        RST = 1'b1;
        step(1);
        check_vec("mr_req", {31'd0, bus0.imem_req}, 32'd0);
        check_if("mr", 1'b0, 32'h0);
        RST = 1'b0;
        step(1);
        check_vec("mr2_addr", bus0.imem_addr, 32'h0000_0000);
        check_vec("mr2_req", {31'd0, bus0.imem_req}, 32'd1);
        check_if("mr2", 1'b0, 32'h0);
        step(1);
        check_if("mr3", BYP, 32'h0);
        step(1);
        check_if("mr4", 1'b1, BYP ? 32'h4 : 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
